bitline_integrator: RTL and testbench
=====================================

# bitline_integrator

Windowed, weighted bitline integrator: the parametrised successor to the binary spike counter. Each column accumulates multi-bit current samples with saturating arithmetic over a programmable integration window. A control FSM (idle / integrate / done) sequences each window, and a valid/ready handshake hands completed sums to the downstream neuron/ADC stage. It sits between the crossbar bitline sense stage and the neuron update logic.

## Interface
Parameters:
- COLS, 32, number of bitline columns
- DATA_WIDTH, 4, unsigned width of one column sample
- ACC_WIDTH, 16, per-column accumulator width; must be >= DATA_WIDTH
- WIN_WIDTH, 10, width of the window-length field

Ports:
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a new window; honoured only in IDLE, or in DONE with handshake completing
- abort  in  1  synchronous abort; returns to IDLE from any state
- window_len  in  WIN_WIDTH  number of accepted samples per window; latched on accepted start
- sample_valid  in  1  samples bus carries a sample this cycle
- samples  in  COLS*DATA_WIDTH  column c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
- busy  out  1  high in INTEGRATE
- out_valid  out  1  high in DONE
- out_ready  in  1  downstream accepts result
- out_sums  out  COLS*ACC_WIDTH  column c at [c*ACC_WIDTH +: ACC_WIDTH]; accumulator registers
- out_sat  out  COLS  per-column sticky saturation flag for current window
- sample_dropped  out  1  registered one-cycle pulse: sample_valid seen outside INTEGRATE

## Operation
- States: IDLE, INTEGRATE, DONE. Reset state is IDLE.
- Reset values: busy=0, out_valid=0, out_sums all 0, out_sat all 0, sample_dropped=0, internal count=0, latched length=0.
- IDLE, start=1:
  - window_len != 0: clear sums and out_sat, latch window_len, count=0, go to INTEGRATE.
  - window_len == 0: clear sums and out_sat, go directly to DONE with zero sums.
- IDLE, start=0: hold. Sums keep the last result.
- INTEGRATE, sample_valid=1:
  - For each column, sum = min(sum + zero-extended sample, 2^ACC_WIDTH-1).
  - out_sat[c] is set if the column clipped this cycle; it stays set until the next window clear.
  - count increments.
  - If this is sample number len (count == len-1 before increment), go to DONE.
- INTEGRATE, sample_valid=0: hold sums and count. Gaps are allowed and do not count.
- start in INTEGRATE is ignored. The window is not restarted.
- DONE:
  - out_valid=1. out_sums and out_sat are frozen.
  - When out_valid && out_ready: if start=1 the same cycle, the new window is accepted with the IDLE rules (back-to-back); otherwise go to IDLE.
  - Without ready, hold indefinitely.
- abort=1, any state: next state IDLE, sums, out_sat and count cleared. Abort has priority over start, samples and handshake.
- sample_dropped pulses the cycle after sample_valid=1 in IDLE or DONE, including the DONE cycle where the handshake completes. Dropped samples never modify sums.
- Arithmetic: unsigned only. Saturation is per column and independent; other columns keep accumulating. A column already at max stays at max with its flag set.

## Timing
- Start accepted at edge T: busy=1 from T+1. The first sample is accepted at T+1.
- Last sample accepted at edge L: out_valid=1 and final sums visible from L+1. Start-to-result latency is len cycles minimum (no gaps).
- Handshake at edge H: out_valid=0 from H+1 unless a back-to-back start with len=0 was accepted. With back-to-back start and len>0, busy=1 from H+1.
- window_len is sampled only at start acceptance. Later changes do not affect the running window.
- Reset assertion mid-window immediately zeroes all state and outputs, asynchronously. The first start is accepted on the first edge after deassertion.

## Test plan
- COLS=4, DATA_WIDTH=4, len=3; samples {1,2,3,4} on three consecutive cycles -> out_valid 3 cycles after start edge, out_sums={3,6,9,12}, out_sat=0.
- len=4 with sample_valid toggled 1,0,1,0,1,0,1 -> sums reflect exactly 4 samples. out_valid rises the cycle after the 4th valid.
- ACC_WIDTH=6, column 0 fed 15 for len=5 -> sum0=63, out_sat[0]=1. Other columns fed 1 -> sum=5, sat=0.
- Hold out_ready=0 for 10 cycles in DONE while driving samples -> sums stable, sample_dropped pulses each cycle. Then ready+start same cycle with len=2 -> busy next cycle, new window starts from zero.
- len=0 start -> DONE next cycle, sums all 0. Abort mid-window (after 2 of 5 samples) -> IDLE next cycle, sums 0, no out_valid.
- Assert rst_n=0 mid-window for 1 cycle -> all outputs 0 immediately. A new window after release runs correctly.

Source files
------------

// File: rtl/bitline_integrator.sv
// Windowed, weighted bitline integrator: per-column saturating accumulation of
// multi-bit samples over a programmable window, results handed off via valid/ready.
module bitline_integrator #(
    parameter int unsigned COLS       = 32,
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned ACC_WIDTH  = 16,
    parameter int unsigned WIN_WIDTH  = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [WIN_WIDTH-1:0]       window_len,
    input  logic                       sample_valid,
    input  logic [COLS*DATA_WIDTH-1:0] samples,
    output logic                       busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [COLS*ACC_WIDTH-1:0]  out_sums,
    output logic [COLS-1:0]            out_sat,
    output logic                       sample_dropped
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INTEGRATE,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [COLS*ACC_WIDTH-1:0]  sums_q, sums_d;
    logic [COLS-1:0]            sat_q, sat_d;
    logic [WIN_WIDTH-1:0]       count_q, count_d;
    logic [WIN_WIDTH-1:0]       len_q, len_d;
    logic                       dropped_q, dropped_d;

    logic [COLS*ACC_WIDTH-1:0]  add_sums;
    logic [COLS-1:0]            add_clip;
    logic                       start_ok;
    logic                       last_sample;

    // Per-column saturating add, one spare bit catches the carry-out.
    always_comb begin : sat_add
        logic [ACC_WIDTH:0] wide;
        add_sums = '0;
        add_clip = '0;
        wide     = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            wide = {1'b0, sums_q[c*ACC_WIDTH +: ACC_WIDTH]}
                 + (ACC_WIDTH+1)'(samples[c*DATA_WIDTH +: DATA_WIDTH]);
            if (wide[ACC_WIDTH]) begin
                add_sums[c*ACC_WIDTH +: ACC_WIDTH] = '1;
                add_clip[c]                        = 1'b1;
            end else begin
                add_sums[c*ACC_WIDTH +: ACC_WIDTH] = wide[ACC_WIDTH-1:0];
            end
        end
    end

    assign start_ok    = start && ((state_q == S_IDLE) ||
                                   ((state_q == S_DONE) && out_ready));
    assign last_sample = (count_q == len_q - 1'b1);

    always_comb begin
        state_d   = state_q;
        sums_d    = sums_q;
        sat_d     = sat_q;
        count_d   = count_q;
        len_d     = len_q;
        dropped_d = sample_valid && (state_q != S_INTEGRATE);

        if (abort) begin
            state_d = S_IDLE;
            sums_d  = '0;
            sat_d   = '0;
            count_d = '0;
        end else if (start_ok) begin
            // Covers both a fresh start in IDLE and a back-to-back start in DONE.
            sums_d  = '0;
            sat_d   = '0;
            count_d = '0;
            len_d   = window_len;
            state_d = (window_len == '0) ? S_DONE : S_INTEGRATE;
        end else begin
            case (state_q)
                S_INTEGRATE: begin
                    if (sample_valid) begin
                        sums_d  = add_sums;
                        sat_d   = sat_q | add_clip;
                        count_d = count_q + 1'b1;
                        if (last_sample) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sums_q    <= '0;
            sat_q     <= '0;
            count_q   <= '0;
            len_q     <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sums_q    <= sums_d;
            sat_q     <= sat_d;
            count_q   <= count_d;
            len_q     <= len_d;
            dropped_q <= dropped_d;
        end
    end

    assign busy           = (state_q == S_INTEGRATE);
    assign out_valid      = (state_q == S_DONE);
    assign out_sums       = sums_q;
    assign out_sat        = sat_q;
    assign sample_dropped = dropped_q;

endmodule

// File: tb/tb_bitline_integrator.sv
// Directed scoreboard bench for bitline_integrator: four columns, 6-bit
// accumulators so saturation is reachable in a few samples.
module tb_bitline_integrator;

    localparam int unsigned COLS = 4;
    localparam int unsigned DW   = 4;
    localparam int unsigned AW   = 6;
    localparam int unsigned WW   = 10;
    localparam int unsigned AMAX = (1 << AW) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 abort;
    logic [WW-1:0]        window_len;
    logic                 sample_valid;
    logic [COLS*DW-1:0]   samples;
    logic                 busy;
    logic                 out_valid;
    logic                 out_ready;
    logic [COLS*AW-1:0]   out_sums;
    logic [COLS-1:0]      out_sat;
    logic                 sample_dropped;

    typedef struct {
        logic [COLS*AW-1:0] sums;
        logic [COLS-1:0]    sat;
    } res_t;

    res_t sb_q[$];
    res_t last_exp;
    int   checks = 0;
    int   errors = 0;

    bitline_integrator #(
        .COLS      (COLS),
        .DATA_WIDTH(DW),
        .ACC_WIDTH (AW),
        .WIN_WIDTH (WW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .window_len    (window_len),
        .sample_valid  (sample_valid),
        .samples       (samples),
        .busy          (busy),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sums      (out_sums),
        .out_sat       (out_sat),
        .sample_dropped(sample_dropped)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: n identical samples accumulated with clamp at AMAX.
    function automatic res_t model(input logic [COLS*DW-1:0] smp, input int n);
        res_t r;
        r.sums = '0;
        r.sat  = '0;
        for (int c = 0; c < COLS; c++) begin
            int acc;
            logic [DW-1:0] s;
            s   = smp[c*DW +: DW];
            acc = 0;
            for (int k = 0; k < n; k++) begin
                acc = acc + int'(s);
                if (acc > int'(AMAX)) begin
                    acc      = int'(AMAX);
                    r.sat[c] = 1'b1;
                end
            end
            r.sums[c*AW +: AW] = AW'(acc);
        end
        return r;
    endfunction

    task automatic check_result(input string tag);
        res_t e;
        checks++;
        assert (sb_q.size() != 0) else begin
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb_q.size() != 0) begin
            e        = sb_q.pop_front();
            last_exp = e;
            check({tag, "_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_sums"}, 64'(out_sums), 64'(e.sums));
            check({tag, "_sat"}, 64'(out_sat), 64'(e.sat));
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (out_valid) break;
            tick();
        end
        check({tag, "_timeout"}, 64'(out_valid), 64'd1);
    endtask

    task automatic start_win(input logic [WW-1:0] len);
        start      = 1'b1;
        window_len = len;
        tick();
        start = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        window_len   = '0;
        sample_valid = 1'b0;
        samples      = '0;
        out_ready    = 1'b0;
        last_exp.sums = '0;
        last_exp.sat  = '0;
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_sums", 64'(out_sums), 64'd0);
        check("rst_sat", 64'(out_sat), 64'd0);
        check("rst_drop", 64'(sample_dropped), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic window, len=3, and window_len changed after acceptance.
        samples = {4'd4, 4'd3, 4'd2, 4'd1};
        sb_q.push_back(model(samples, 3));
        start_win(10'd3);
        window_len   = 10'd7;
        sample_valid = 1'b1;
        check("t1_busy", 64'(busy), 64'd1);
        tick();
        tick();
        check("t1_early", 64'(out_valid), 64'd0);
        tick();
        sample_valid = 1'b0;
        check_result("t1");
        handshake();
        check("t1_idle", 64'(out_valid), 64'd0);
        check("t1_idle_busy", 64'(busy), 64'd0);

        // Gapped samples: only valid cycles count.
        samples = {4'd3, 4'd0, 4'd1, 4'd2};
        sb_q.push_back(model(samples, 4));
        start_win(10'd4);
        for (int i = 0; i < 7; i++) begin
            sample_valid = (i % 2 == 0);
            if (i == 6) check("t2_early", 64'(out_valid), 64'd0);
            tick();
        end
        sample_valid = 1'b0;
        check_result("t2");

        // Stall in DONE while samples arrive: sums frozen, drops flagged.
        out_ready    = 1'b0;
        samples      = '1;
        sample_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_hold_sums", 64'(out_sums), 64'(last_exp.sums));
            check("t4_hold_drop", 64'(sample_dropped), 64'd1);
        end
        check("t4_hold_valid", 64'(out_valid), 64'd1);
        samples    = {4'd1, 4'd1, 4'd1, 4'd1};
        sb_q.push_back(model(samples, 2));
        out_ready  = 1'b1;
        start      = 1'b1;
        window_len = 10'd2;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check("t4_b2b_busy", 64'(busy), 64'd1);
        check("t4_b2b_valid", 64'(out_valid), 64'd0);
        check("t4_b2b_clear", 64'(out_sums), 64'd0);
        check("t4_b2b_drop", 64'(sample_dropped), 64'd1);
        tick();
        check("t4_nodrop", 64'(sample_dropped), 64'd0);
        tick();
        sample_valid = 1'b0;
        check_result("t4");
        handshake();

        // Saturation on column 0 only.
        samples = {4'd1, 4'd1, 4'd1, 4'd15};
        sb_q.push_back(model(samples, 5));
        start_win(10'd5);
        sample_valid = 1'b1;
        wait_valid("t3", 10);
        sample_valid = 1'b0;
        check("t3_sat_flag", 64'(out_sat), 64'h1);
        check("t3_col0", 64'(out_sums[AW-1:0]), 64'(AMAX));
        check_result("t3");
        handshake();

        // Zero-length window goes straight to DONE.
        sb_q.push_back(model(samples, 0));
        start_win(10'd0);
        check("t5_zero_busy", 64'(busy), 64'd0);
        check_result("t5_zero");
        handshake();
        check("t5_zero_idle", 64'(out_valid), 64'd0);

        // Abort mid-window after two of five samples.
        samples = {4'd3, 4'd3, 4'd3, 4'd3};
        start_win(10'd5);
        sample_valid = 1'b1;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort        = 1'b0;
        sample_valid = 1'b0;
        check("t5_abort_busy", 64'(busy), 64'd0);
        check("t5_abort_valid", 64'(out_valid), 64'd0);
        check("t5_abort_sums", 64'(out_sums), 64'd0);
        check("t5_abort_drop", 64'(sample_dropped), 64'd0);
        tick();
        tick();
        check("t5_abort_stay", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-window, then a clean window.
        samples = {4'd2, 4'd2, 4'd2, 4'd2};
        start_win(10'd3);
        sample_valid = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_sums", 64'(out_sums), 64'd0);
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        tick();
        rst_n        = 1'b1;
        sample_valid = 1'b0;
        samples      = {4'd8, 4'd7, 4'd6, 4'd5};
        sb_q.push_back(model(samples, 2));
        start_win(10'd2);
        sample_valid = 1'b1;
        wait_valid("t6", 5);
        sample_valid = 1'b0;
        check_result("t6");
        handshake();

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
